// File: rtl/dm_responder.sv
// Data-memory responder: load/store slave port with byte/half/word lanes,
// load extension, misalignment errors and programmable wait states.
module dm_responder #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_err_store
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   state_t             state, state_nxt;
   logic [3:0]         cnt;

   logic               lat_we;
   logic [1:0]         lat_size;
   logic               lat_signed;
   logic [ADDR_W+1:0]  lat_addr;
   logic [31:0]        lat_wdata;

   logic               op_we;
   logic [1:0]         op_size;
   logic               op_signed;
   logic [ADDR_W+1:0]  op_addr;
   logic [31:0]        op_wdata;

   logic [31:0]        mem [(2**ADDR_W)-1:0];
   logic [ADDR_W-1:0]  op_idx;
   logic [31:0]        rd_word;
   logic [31:0]        wr_word;
   logic [31:0]        ld_data;
   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic               misaligned;
   logic               enter_resp;
   logic               do_write;
   logic               unused_addr_hi;

   assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
   assign req_ready      = (state == IDLE);

   // With zero wait states the access happens on the accept edge itself,
   // so the operation is taken from the live request while still in IDLE.
   always_comb begin
      op_we     = lat_we;
      op_size   = lat_size;
      op_signed = lat_signed;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
      if (state == IDLE) begin
         op_we     = req_we;
         op_size   = req_size;
         op_signed = req_signed;
         op_addr   = req_addr[ADDR_W+1:0];
         op_wdata  = req_wdata;
      end
   end

   always_comb begin
      misaligned = 1'b0;
      case (op_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = op_addr[0];
         2'b10:   misaligned = (op_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   assign op_idx  = op_addr[ADDR_W+1:2];
   assign rd_word = mem[op_idx];

   always_comb begin
      ld_byte = rd_word[7:0];
      case (op_addr[1:0])
         2'b00:   ld_byte = rd_word[7:0];
         2'b01:   ld_byte = rd_word[15:8];
         2'b10:   ld_byte = rd_word[23:16];
         default: ld_byte = rd_word[31:24];
      endcase
      ld_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
   end

   always_comb begin
      ld_data = rd_word;
      case (op_size)
         2'b00:   ld_data = op_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
         2'b01:   ld_data = op_signed ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
         default: ld_data = rd_word;
      endcase
   end

   always_comb begin
      wr_word = rd_word;
      case (op_size)
         2'b00: begin
            case (op_addr[1:0])
               2'b00:   wr_word[7:0]   = op_wdata[7:0];
               2'b01:   wr_word[15:8]  = op_wdata[7:0];
               2'b10:   wr_word[23:16] = op_wdata[7:0];
               default: wr_word[31:24] = op_wdata[7:0];
            endcase
         end
         2'b01: begin
            if (op_addr[1]) wr_word[31:16] = op_wdata[15:0];
            else            wr_word[15:0]  = op_wdata[15:0];
         end
         2'b10:   wr_word = op_wdata;
         default: wr_word = rd_word;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (req_valid)
               state_nxt = (misaligned || (WAIT_INIT == 4'd0)) ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt <= 4'd1) state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // RESP always exits to IDLE, so a next state of RESP marks the entry edge.
   assign enter_resp = (state_nxt == RESP) && (state != RESP);
   assign do_write   = enter_resp && op_we && !misaligned && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         lat_we        <= 1'b0;
         lat_size      <= '0;
         lat_signed    <= 1'b0;
         lat_addr      <= '0;
         lat_wdata     <= '0;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_err       <= 1'b0;
         rsp_err_store <= 1'b0;
      end else begin
         state     <= state_nxt;
         rsp_valid <= enter_resp;
         if (state == IDLE && req_valid) begin
            lat_we     <= req_we;
            lat_size   <= req_size;
            lat_signed <= req_signed;
            lat_addr   <= req_addr[ADDR_W+1:0];
            lat_wdata  <= req_wdata;
            cnt        <= WAIT_INIT;
         end else if (state == WAIT) begin
            cnt <= cnt - 4'd1;
         end
         if (enter_resp) begin
            rsp_err       <= misaligned;
            rsp_err_store <= misaligned & op_we;
            rsp_rdata     <= (misaligned || op_we) ? '0 : ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_write) mem[op_idx] <= wr_word;
   end

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: three instances (1, 3 and 0 wait states)
// share clk/rst; expected responses are queued and compared as they arrive.
module tb_dm_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic        st;
      logic [7:0]  lat;
   } rsp_t;

   logic        clk;
   logic        rst;
   logic        req_valid     [3];
   logic        req_ready     [3];
   logic        req_we        [3];
   logic [1:0]  req_size      [3];
   logic        req_signed    [3];
   logic [31:0] req_addr      [3];
   logic [31:0] req_wdata     [3];
   logic        rsp_valid     [3];
   logic [31:0] rsp_rdata     [3];
   logic        rsp_err       [3];
   logic        rsp_err_store [3];

   rsp_t exp_q[$];
   rsp_t got_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   dm_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
      .req_size(req_size[0]), .req_signed(req_signed[0]), .req_addr(req_addr[0]),
      .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .rsp_err_store(rsp_err_store[0]));

   dm_responder #(.ADDR_W(10), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
      .req_size(req_size[1]), .req_signed(req_signed[1]), .req_addr(req_addr[1]),
      .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .rsp_err_store(rsp_err_store[1]));

   dm_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
      .req_size(req_size[2]), .req_signed(req_signed[2]), .req_addr(req_addr[2]),
      .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_err(rsp_err[2]), .rsp_err_store(rsp_err_store[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic rsp_t mk(input logic [31:0] rd, input logic e, input logic s,
                               input int lat);
      rsp_t r;
      r.rdata = rd;
      r.err   = e;
      r.st    = s;
      r.lat   = 8'(lat);
      return r;
   endfunction

   // Drives one request on instance d and records the response with its latency,
   // counted in edges from (and including) the accept edge.
   task automatic issue(input int d, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
      rsp_t g;
      int   n;
      @(negedge clk);
      n = 0;
      while (!req_ready[d] && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_we[d]     = we;
      req_size[d]   = sz;
      req_signed[d] = sg;
      req_addr[d]   = a;
      req_wdata[d]  = wd;
      req_valid[d]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[d] = 1'b0;
      n = 1;
      while (!rsp_valid[d] && n < 40) begin
         @(negedge clk);
         n++;
      end
      g.rdata = rsp_rdata[d];
      g.err   = rsp_err[d];
      g.st    = rsp_err_store[d];
      g.lat   = (n >= 40) ? 8'hFF : 8'(n);
      got_q.push_back(g);
   endtask

   task automatic test_reset();
      logic [35:0] obs;
      for (int d = 0; d < 3; d++) begin
         obs = {req_ready[d], rsp_valid[d], rsp_err[d], rsp_err_store[d], rsp_rdata[d]};
         n_checks++;
         if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset[%0d]: got ready/valid/err/st/rdata=%h, expected %h",
                     d, obs, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
         end
      end
   endtask

   task automatic test_store_load();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'h0, 0, 0, 2));        issue(0, 1, 2'b10, 0, 32'h10, 32'h8899AABB);
      exp_q.push_back(mk(32'h8899AABB, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL store_load[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_extension();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'hFFFFFFAA, 0, 0, 2)); issue(0, 0, 2'b00, 1, 32'h11, 32'h0);
      exp_q.push_back(mk(32'h000000AA, 0, 0, 2)); issue(0, 0, 2'b00, 0, 32'h11, 32'h0);
      exp_q.push_back(mk(32'hFFFF8899, 0, 0, 2)); issue(0, 0, 2'b01, 1, 32'h12, 32'h0);
      exp_q.push_back(mk(32'h00008899, 0, 0, 2)); issue(0, 0, 2'b01, 0, 32'h12, 32'h0);
      exp_q.push_back(mk(32'hFFFFFFBB, 0, 0, 2)); issue(0, 0, 2'b00, 1, 32'h10, 32'h0);
      exp_q.push_back(mk(32'h8899AABB, 0, 0, 2)); issue(0, 0, 2'b10, 1, 32'h10, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL extension[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_partial_store();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'h0, 0, 0, 2));        issue(0, 1, 2'b00, 0, 32'h13, 32'h12345677);
      exp_q.push_back(mk(32'h7799AABB, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      exp_q.push_back(mk(32'h0, 0, 0, 2));        issue(0, 1, 2'b01, 0, 32'h10, 32'h0000CAFE);
      exp_q.push_back(mk(32'h7799CAFE, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL partial_store[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_misalign();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'h0, 1, 0, 1));        issue(0, 0, 2'b10, 0, 32'h12, 32'h0);
      exp_q.push_back(mk(32'h0, 1, 1, 1));        issue(0, 1, 2'b01, 0, 32'h11, 32'h00001111);
      exp_q.push_back(mk(32'h0, 1, 1, 1));        issue(0, 1, 2'b11, 0, 32'h10, 32'h22222222);
      exp_q.push_back(mk(32'h0, 1, 0, 1));        issue(0, 0, 2'b01, 1, 32'h13, 32'h0);
      exp_q.push_back(mk(32'h7799CAFE, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL misalign[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_alias();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'h7799CAFE, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h1010, 32'h0);
      exp_q.push_back(mk(32'h0, 0, 0, 2));        issue(0, 1, 2'b00, 0, 32'hFFFF_F012, 32'h55);
      exp_q.push_back(mk(32'h7755CAFE, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL alias[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_handshake();
      rsp_t       e, g;
      rsp_t       r;
      logic [5:0] rdy, vld;
      exp_q.push_back(mk(32'h0, 0, 0, 4));
      issue(1, 1, 2'b10, 0, 32'h40, 32'h01020304);
      exp_q.push_back(mk(32'h01020304, 0, 0, 4));
      @(negedge clk);
      req_we[1]     = 1'b0;
      req_size[1]   = 2'b10;
      req_signed[1] = 1'b0;
      req_addr[1]   = 32'h40;
      req_valid[1]  = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (k > 0) begin
            @(posedge clk);
            @(negedge clk);
         end
         rdy[5-k] = req_ready[1];
         vld[5-k] = rsp_valid[1];
         if (rsp_valid[1]) begin
            r.rdata = rsp_rdata[1];
            r.err   = rsp_err[1];
            r.st    = rsp_err_store[1];
            r.lat   = 8'(k);
            got_q.push_back(r);
         end
      end
      req_valid[1] = 1'b0;
      n_checks++;
      if (rdy !== 6'b100001) begin
         n_fail++;
         $display("FAIL handshake_ready: got %b, expected %b", rdy, 6'b100001);
      end
      n_checks++;
      if (vld !== 6'b000010) begin
         n_fail++;
         $display("FAIL handshake_valid: got %b, expected %b", vld, 6'b000010);
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL handshake[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
      end
   endtask

   task automatic test_zero_wait();
      rsp_t e, g;
      int   i = 0;
      exp_q.push_back(mk(32'h0, 0, 0, 1));        issue(2, 1, 2'b10, 0, 32'h8, 32'hA5A55A5A);
      exp_q.push_back(mk(32'hFFFFFFA5, 0, 0, 1)); issue(2, 0, 2'b00, 1, 32'hB, 32'h0);
      exp_q.push_back(mk(32'h00005A5A, 0, 0, 1)); issue(2, 0, 2'b01, 0, 32'h8, 32'h0);
      exp_q.push_back(mk(32'h0, 1, 0, 1));        issue(2, 0, 2'b10, 0, 32'h9, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL zero_wait[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   task automatic test_reset_mid();
      rsp_t        e, g;
      logic [35:0] obs;
      int          i = 0;
      exp_q.push_back(mk(32'h0, 0, 0, 2));        issue(0, 1, 2'b10, 0, 32'h20, 32'h0);
      exp_q.push_back(mk(32'h7755CAFE, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
      @(negedge clk);
      req_we[0]    = 1'b1;
      req_size[0]  = 2'b10;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'hDEADBEEF;
      req_valid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid[0] = 1'b0;
      n_checks++;
      if (req_ready[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got req_ready=%b, expected 0", req_ready[0]);
      end
      rst = 1'b1;
      #1;
      obs = {req_ready[0], rsp_valid[0], rsp_err[0], rsp_err_store[0], rsp_rdata[0]};
      n_checks++;
      if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_mid_outputs: got ready/valid/err/st/rdata=%h, expected %h",
                  obs, {1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(mk(32'h0, 0, 0, 2)); issue(0, 0, 2'b10, 0, 32'h20, 32'h0);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = (got_q.size() > 0) ? got_q.pop_front() : '1;
         n_checks++;
         if (g !== e) begin
            n_fail++;
            $display("FAIL reset_mid[%0d]: got rdata=%h err=%b st=%b lat=%0d, expected rdata=%h err=%b st=%b lat=%0d",
                     i, g.rdata, g.err, g.st, g.lat, e.rdata, e.err, e.st, e.lat);
         end
         i++;
      end
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         req_valid[d]  = 1'b0;
         req_we[d]     = 1'b0;
         req_size[d]   = 2'b00;
         req_signed[d] = 1'b0;
         req_addr[d]   = 32'h0;
         req_wdata[d]  = 32'h0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst = 1'b0;
      test_store_load();
      test_extension();
      test_partial_store();
      test_misalign();
      test_alias();
      test_handshake();
      test_zero_wait();
      test_reset_mid();
      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
